// File: rtl/key_expansion_ctrl.sv
// Sequential AES-128 key-expansion controller: one keyschedule round per clock into a
// round-key file, served through a registered read port.
module key_expansion_ctrl #(
  parameter int ROUNDS = 10,
  parameter int KEY_W  = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [KEY_W-1:0] key_in,
  output logic             busy,
  output logic             done,
  output logic             key_valid,
  input  logic [3:0]       rd_addr,
  output logic [KEY_W-1:0] rd_key
);

  typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

  state_t           state_q, state_d;
  logic [3:0]       round_q, round_d;
  logic [KEY_W-1:0] work_q, work_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             key_valid_q, key_valid_d;
  logic [KEY_W-1:0] rd_key_q, rd_key_d;
  logic [KEY_W-1:0] mem_q [ROUNDS+1];
  logic [KEY_W-1:0] mem_d [ROUNDS+1];
  logic [KEY_W-1:0] ks_out;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = xtime(x);
    end
    return acc;
  endfunction

  // S-box = affine(x^254); x^254 is the GF(2^8) inverse and maps 0 to 0.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] key_round(input logic [127:0] k, input logic [3:0] r);
    logic [31:0] w0, w1, w2, w3, rot, t;
    w0  = k[127:96];
    w1  = k[95:64];
    w2  = k[63:32];
    w3  = k[31:0];
    rot = {w3[23:0], w3[31:24]};
    t   = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])} ^
          {rcon(r), 24'h000000};
    w0  = w0 ^ t;
    w1  = w1 ^ w0;
    w2  = w2 ^ w1;
    w3  = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // The single keyschedule datapath, shared by every expansion round.
  always_comb begin
    ks_out = key_round(work_q, round_q);
  end

  always_comb begin
    state_d     = state_q;
    round_d     = round_q;
    work_d      = work_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    key_valid_d = key_valid_q;
    mem_d       = mem_q;
    case (state_q)
      IDLE, READY: begin
        if (start) begin
          mem_d[0]    = key_in;
          work_d      = key_in;
          round_d     = 4'd1;
          busy_d      = 1'b1;
          key_valid_d = 1'b0;
          state_d     = EXPAND;
        end
      end
      EXPAND: begin
        for (int i = 1; i <= ROUNDS; i++) begin
          if (round_q == 4'(i)) mem_d[i] = ks_out;
        end
        work_d  = ks_out;
        round_d = round_q + 4'd1;
        if (round_q == 4'(ROUNDS)) begin
          busy_d      = 1'b0;
          done_d      = 1'b1;
          key_valid_d = 1'b1;
          round_d     = 4'd0;
          state_d     = READY;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reads see the file before this edge's write; out-of-range indices return zero.
  always_comb begin
    rd_key_d = '0;
    for (int i = 0; i <= ROUNDS; i++) begin
      if (rd_addr == 4'(i)) rd_key_d = mem_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      round_q     <= 4'd0;
      work_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      key_valid_q <= 1'b0;
      rd_key_q    <= '0;
      for (int i = 0; i <= ROUNDS; i++) mem_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      round_q     <= round_d;
      work_q      <= work_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      key_valid_q <= key_valid_d;
      rd_key_q    <= rd_key_d;
      for (int i = 0; i <= ROUNDS; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign key_valid = key_valid_q;
  assign rd_key    = rd_key_q;

endmodule

// File: tb/tb_key_expansion_ctrl.sv
// Bench for key_expansion_ctrl: FIPS-197 vector table, multi-cycle corner sequences and
// random keys checked against a word-level key-expansion model.
module tb_key_expansion_ctrl;
  localparam int ROUNDS = 10;
  localparam logic [127:0] KA = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KC = 128'h000102030405060708090a0b0c0d0e0f;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] key_in;
  logic         busy;
  logic         done;
  logic         key_valid;
  logic [3:0]   rd_addr;
  logic [127:0] rd_key;

  int checks = 0;
  int errors = 0;

  logic [7:0]   sbox_t  [256];
  logic [127:0] model_rk[ROUNDS+1];
  logic [127:0] file_m  [ROUNDS+1];

  typedef struct {
    logic [127:0] key;
    logic [3:0]   addr;
    logic [127:0] want;
  } vec_t;
  vec_t vecs[7];

  always #5 clk = ~clk;

  key_expansion_ctrl #(.ROUNDS(ROUNDS), .KEY_W(128)) dut (
    .clk(clk), .rst(rst), .start(start), .key_in(key_in),
    .busy(busy), .done(done), .key_valid(key_valid),
    .rd_addr(rd_addr), .rd_key(rd_key)
  );

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got running required finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, want);
    end
  endtask

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction

  // S-box generated by the multiply-by-3 / divide-by-3 walk over the field.
  function automatic void build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    sbox_t[0] = 8'h63;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
  endfunction

  function automatic void model_expand(input logic [127:0] k);
    logic [31:0] w[4*(ROUNDS+1)];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 4*(ROUNDS+1); i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= ROUNDS; r++) model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [127:0] exp_rd(input logic [3:0] a);
    if (int'(a) <= ROUNDS) return file_m[int'(a)];
    return '0;
  endfunction

  task automatic launch(input logic [127:0] k);
    @(negedge clk);
    start  = 1'b1;
    key_in = k;
    model_expand(k);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Called right after the accepting edge; poke >= 0 pulses start with a foreign key mid-run.
  task automatic wait_expansion(input string tag, input int poke);
    for (int n = 0; n <= ROUNDS; n++) begin
      @(negedge clk);
      if (n < ROUNDS) begin
        check($sformatf("%s busy@%0d", tag, n), 128'(busy), 128'(1));
        check($sformatf("%s done@%0d", tag, n), 128'(done), 128'(0));
        check($sformatf("%s key_valid@%0d", tag, n), 128'(key_valid), 128'(0));
      end else begin
        check($sformatf("%s busy_end", tag), 128'(busy), 128'(0));
        check($sformatf("%s done_end", tag), 128'(done), 128'(1));
        check($sformatf("%s key_valid_end", tag), 128'(key_valid), 128'(1));
      end
      if (n == poke) begin
        start  = 1'b1;
        key_in = {$urandom, $urandom, $urandom, $urandom};
      end else begin
        start = 1'b0;
      end
    end
    for (int r = 0; r <= ROUNDS; r++) file_m[r] = model_rk[r];
    $display("expansion %s: complete", tag);
  endtask

  // Change rd_addr every cycle and check the previous address one cycle later.
  task automatic sweep(input string tag, input int n, input bit rnd);
    logic [3:0] prev;
    @(negedge clk);
    prev    = rnd ? 4'($urandom_range(0, 15)) : 4'd0;
    rd_addr = prev;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check($sformatf("%s rd_key[%0d]", tag, prev), rd_key, exp_rd(prev));
      $display("read %s addr=%0d rd_key=%h", tag, prev, rd_key);
      prev    = rnd ? 4'($urandom_range(0, 15)) : 4'(i + 1);
      rd_addr = prev;
    end
  endtask

  initial begin
    int         done_cyc[$];
    int         dcount;
    logic [127:0] loaded;

    build_sbox();
    rst = 1'b1; start = 1'b0; key_in = '0; rd_addr = 4'd0;
    for (int r = 0; r <= ROUNDS; r++) file_m[r] = '0;

    vecs[0] = '{KA, 4'd0,  KA};
    vecs[1] = '{KA, 4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
    vecs[2] = '{KA, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vecs[3] = '{KA, 4'd11, 128'h0};
    vecs[4] = '{KC, 4'd0,  KC};
    vecs[5] = '{KC, 4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5};
    vecs[6] = '{KC, 4'd15, 128'h0};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset busy", 128'(busy), 128'(0));
    check("reset done", 128'(done), 128'(0));
    check("reset key_valid", 128'(key_valid), 128'(0));
    check("reset rd_key", rd_key, 128'h0);
    rst = 1'b0;
    @(negedge clk);
    check("release rd_key", rd_key, 128'h0);
    $display("reset: checked");

    // Known-answer table (second key is a re-key from READY)
    loaded = 'x;
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].key !== loaded) begin
        launch(vecs[i].key);
        wait_expansion($sformatf("vec%0d", i), -1);
        loaded = vecs[i].key;
      end
      @(negedge clk);
      rd_addr = vecs[i].addr;
      @(negedge clk);
      check($sformatf("vec%0d rd_key[%0d]", i, vecs[i].addr), rd_key, vecs[i].want);
      $display("vector %0d addr=%0d rd_key=%h", i, vecs[i].addr, rd_key);
    end

    // Start during EXPAND with another key is ignored
    launch(KA);
    wait_expansion("ignore_start", 3);
    @(negedge clk);
    check("ignore_start no_rerun busy", 128'(busy), 128'(0));
    sweep("ignore_start", 11, 1'b0);

    // Start held for 15 edges: one re-key in the done cycle, exactly two done pulses
    model_expand(KA);
    @(negedge clk);
    start = 1'b1; key_in = KA;
    for (int c = 0; c < 36; c++) begin
      @(posedge clk);
      #1 if (c == 14) start = 1'b0;
      @(negedge clk);
      if (done) done_cyc.push_back(c);
    end
    check("held_start done_count", 128'(done_cyc.size()), 128'(2));
    if (done_cyc.size() >= 2) begin
      check("held_start first_done", 128'(done_cyc[0]), 128'(ROUNDS));
      check("held_start second_done", 128'(done_cyc[1]), 128'(2*ROUNDS+1));
    end
    for (int r = 0; r <= ROUNDS; r++) file_m[r] = model_rk[r];
    $display("held start: done pulses=%0d", done_cyc.size());
    sweep("held_start", 11, 1'b1);

    // Reset in the middle of an expansion
    launch({$urandom, $urandom, $urandom, $urandom});
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int r = 0; r <= ROUNDS; r++) file_m[r] = '0;
    check("abort busy", 128'(busy), 128'(0));
    check("abort key_valid", 128'(key_valid), 128'(0));
    dcount = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check("abort no_done", 128'(dcount), 128'(0));
    $display("abort: done pulses=%0d", dcount);
    sweep("abort", 16, 1'b0);

    // Random keys against the model, random addresses including out of range
    for (int k = 0; k < 6; k++) begin
      launch({$urandom, $urandom, $urandom, $urandom});
      wait_expansion($sformatf("rand%0d", k), -1);
      sweep($sformatf("rand%0d", k), 20, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
